// File: rtl/irq_pending_arbiter.sv
// rtl/irq_pending_arbiter.sv - sticky pending capture, mask, highest-index grant with valid/ready
module irq_pending_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int ID_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_in,
    input  logic [NUM_REQ-1:0] mask_in,
    output logic               out_valid,
    output logic [ID_W-1:0]    out_id,
    input  logic               out_ready,
    output logic [NUM_REQ-1:0] pending,
    output logic               lost
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] req_q;
    logic [NUM_REQ-1:0] pending_q;
    logic [ID_W-1:0]    out_id_q, out_id_d;
    logic               lost_q;

    logic [NUM_REQ-1:0] rise;
    logic [NUM_REQ-1:0] clr_vec;
    logic [NUM_REQ-1:0] pending_d;
    logic [NUM_REQ-1:0] elig;
    logic [ID_W-1:0]    winner;
    logic               handshake;
    logic               lost_d;

    assign rise      = req_in & ~req_q;
    assign handshake = (state_q == OFFER) && out_ready;
    assign clr_vec   = handshake ? (NUM_REQ'(1) << out_id_q) : '0;
    // Clear before set so a fresh rise on the serviced bit is kept, not reported lost.
    assign pending_d = (pending_q & ~clr_vec) | rise;
    assign lost_d    = |(rise & pending_q & ~clr_vec);
    assign elig      = pending_q & ~mask_in;

    always_comb begin
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (elig[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        out_id_d = out_id_q;
        case (state_q)
            IDLE: begin
                if (elig != '0) begin
                    out_id_d = winner;
                    state_d  = OFFER;
                end
            end
            OFFER: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= '0;
            pending_q <= '0;
            out_id_q  <= '0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_in;
            pending_q <= pending_d;
            out_id_q  <= out_id_d;
            lost_q    <= lost_d;
        end
    end

    assign out_valid = (state_q == OFFER);
    assign out_id    = out_id_q;
    assign pending   = pending_q;
    assign lost      = lost_q;

endmodule

// File: doc/irq_pending_arbiter.md
# irq_pending_arbiter

Request-capture and grant stage that sits directly upstream of the 8-input priority encoder in the interrupt path. It turns raw request lines into sticky pending bits, applies a mask, and selects the highest-index unmasked pending request (bit 7 wins, bit 0 loses). It offers the winning index through a valid/ready handshake and clears the serviced bit on acceptance. The winner's index matches what the priority encoder produces for the masked pending vector, so the two blocks are interchangeable as far as downstream consumers are concerned.

## Interface
- NUM_REQ, 8, number of request lines; fixed at 8 for this revision.
- ID_W, 3, width of the granted index; equals clog2(NUM_REQ).
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- req_in  input  NUM_REQ  raw request lines; a rising edge marks a new request.
- mask_in  input  NUM_REQ  1 = the bit is blocked from arbitration; its pending bit is still kept.
- out_valid  output  1  a grant is being offered.
- out_id  output  ID_W  index of the offered request; held stable while out_valid=1.
- out_ready  input  1  the consumer accepts the offer when out_valid and out_ready are both 1.
- pending  output  NUM_REQ  current sticky pending vector, as registered.
- lost  output  1  one-cycle pulse: a rising edge arrived on a bit that was already pending.

## Operation
- Edge detect: req_q <= req_in every cycle; rise = req_in & ~req_q.
- Pending update each cycle, in this order:
  - clear pending[out_id] if a handshake occurs;
  - then set pending |= rise.
  - A rise on the bit being cleared in the same cycle therefore leaves that bit set (the new request is kept).
- lost <= |(rise & pending) registered, evaluated against pending before the update.
  - The bit being cleared in the same cycle does not count as lost.
- Eligible vector: elig = pending & ~mask_in. The winner is the highest set index of elig.
- FSM states:
  - IDLE: out_valid=0. If elig != 0, register out_id = winner and go to OFFER. Otherwise stay in IDLE.
  - OFFER: out_valid=1 and out_id is frozen. On out_ready=1: clear pending[out_id] and go to IDLE. Otherwise stay in OFFER.
- No preemption: a higher-priority request or a mask change during OFFER does not alter or withdraw the current offer.
- Re-arbitration happens only in IDLE, so there is at least one idle cycle between consecutive grants.
- Arithmetic: out_id is the index as an unsigned ID_W-bit value. No wrap is possible.

## Timing
- Reset (rst=1 at a rising edge) sets:
  - state = IDLE, pending = 0, req_q = 0, out_valid = 0, out_id = 0, lost = 0.
- Because req_q resets to 0, a line held high across reset release counts as a rising edge in the first cycle after reset.
- Reset in the middle of an OFFER drops the offer and every pending bit. No handshake is reported for that cycle.
- Latency: req_in goes high and is sampled at edge t → pending bit visible after t → out_valid=1 after edge t+1 (2 cycles).
- Throughput: at most one grant every 2 cycles (OFFER followed by IDLE) when out_ready is held high.
- out_valid falls in the cycle after the accepting edge. out_id keeps its last value while in IDLE.
- lost is high for exactly one cycle, namely the cycle after the offending edge.
- All-masked case: pending bits accumulate, out_valid stays 0, and the pending output shows them.
- Unmasking a bit while in IDLE makes out_valid rise 1 cycle later.

## Test plan
- Reset release with req_in=8'h00: pending=0, out_valid=0, lost=0 → then pulse req_in[3] for one cycle.
  - Expect out_valid=1 and out_id=3 two cycles after sampling.
  - With out_ready=1, expect pending=0 one cycle later.
- Rising edges on bits 2 and 5 in the same cycle, out_ready=1:
  - grants in the order out_id=5, then out_id=2, with out_valid low for one cycle between them.
- OFFER with out_id=2 and out_ready=0, then raise req_in[7]:
  - out_id stays 2 until accepted;
  - after the next IDLE cycle, out_id=7 is offered.
- mask_in=8'hFF with edges on bits 0 and 6: pending=8'h41 and out_valid=0.
  - Clear mask_in[0] → grant out_id=0.
  - Clear mask_in[6] → grant out_id=6.
- Bit 4 pending and unserviced, and a second rising edge on req_in[4]: lost pulses for exactly 1 cycle and pending stays 8'h10.
  - Second part: rise on bit 4 in the same cycle as the handshake for out_id=4 → lost=0, pending[4] remains 1, and 4 is re-offered.
- rst asserted during OFFER (out_id=6, pending=8'h48): the next cycle shows out_valid=0 and pending=0.
  - req_in[1] held high through reset release yields out_id=1 two cycles later.
